// File: rtl/motor_ramp_seq.sv
// Slews left/right motor commands toward latched targets, brakes through zero, supports estop.
// Latency: outputs registered; targets seen by the tick one cycle after cmd_vld, one STEP per tick.
// Backpressure: none; cmd_vld always accepted, estop overrides commands while high.
module motor_ramp_seq #(
    parameter logic [9:0] STEP     = 10'd16,
    parameter int         TICK_DIV = 1024,
    parameter int         DWELL    = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_vld,
    input  logic [10:0] cmd_lft,
    input  logic [10:0] cmd_rht,
    input  logic        estop,
    output logic [10:0] lft,
    output logic [10:0] rht,
    output logic        settled
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DW_LOAD = DW'(DWELL - 1);

    typedef enum logic {ST_RUN, ST_DWELL} ch_state_t;

    // index 0 = left channel, index 1 = right channel
    ch_state_t      st_q   [2];
    ch_state_t      st_d   [2];
    logic           s_q    [2];
    logic           s_d    [2];
    logic [9:0]     m_q    [2];
    logic [9:0]     m_d    [2];
    logic [DW-1:0]  dw_q   [2];
    logic [DW-1:0]  dw_d   [2];
    logic [10:0]    tgt_q  [2];
    logic [10:0]    tgt_d  [2];
    logic [10:0]    cmd_n  [2];
    logic [10:0]    out_d  [2];
    logic [10:0]    up_sum [2];
    logic [10:0]    dn_lim [2];

    logic [PW-1:0]  pre_q;
    logic           tick;
    logic           settled_d;

    // A zero-magnitude target is stored as plain stop regardless of its sign bit
    assign cmd_n[0] = (cmd_lft[9:0] == 10'd0) ? 11'h000 : cmd_lft;
    assign cmd_n[1] = (cmd_rht[9:0] == 10'd0) ? 11'h000 : cmd_rht;

    assign tick = (pre_q == PRE_MAX);

    // Free-running ramp prescaler
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
        end else if (tick) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + PW'(1);
        end
    end

    // Per-channel next state: estop, target latch, dwell countdown and ramp step
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            st_d[c]   = st_q[c];
            s_d[c]    = s_q[c];
            m_d[c]    = m_q[c];
            dw_d[c]   = dw_q[c];
            tgt_d[c]  = tgt_q[c];
            // 11-bit sums so 1023 + STEP cannot wrap
            up_sum[c] = {1'b0, m_q[c]} + {1'b0, STEP};
            dn_lim[c] = {1'b0, tgt_q[c][9:0]} + {1'b0, STEP};

            if (estop) begin
                tgt_d[c] = 11'h000;
                m_d[c]   = 10'd0;
                st_d[c]  = ST_DWELL;
                dw_d[c]  = DW_LOAD;
            end else begin
                if (cmd_vld) begin
                    tgt_d[c] = cmd_n[c];
                end
                if (st_q[c] == ST_DWELL) begin
                    // Held in brake; ticks are ignored until the counter runs out
                    if (dw_q[c] == '0) begin
                        st_d[c] = ST_RUN;
                    end else begin
                        dw_d[c] = dw_q[c] - DW'(1);
                    end
                end else if (tick) begin
                    if (m_q[c] == 10'd0) begin
                        if (tgt_q[c][9:0] != 10'd0) begin
                            s_d[c] = tgt_q[c][10];
                            m_d[c] = (tgt_q[c][9:0] < STEP) ? tgt_q[c][9:0] : STEP;
                        end
                    end else if (tgt_q[c][10] != s_q[c]) begin
                        // Wrong direction: slow down toward zero first
                        m_d[c] = (m_q[c] > STEP) ? (m_q[c] - STEP) : 10'd0;
                    end else if (m_q[c] < tgt_q[c][9:0]) begin
                        m_d[c] = (up_sum[c] > {1'b0, tgt_q[c][9:0]}) ? tgt_q[c][9:0] : up_sum[c][9:0];
                    end else if (m_q[c] > tgt_q[c][9:0]) begin
                        m_d[c] = ({1'b0, m_q[c]} > dn_lim[c]) ? (m_q[c] - STEP) : tgt_q[c][9:0];
                    end
                    // Passing through zero always earns a brake dwell
                    if ((m_q[c] != 10'd0) && (m_d[c] == 10'd0)) begin
                        st_d[c] = ST_DWELL;
                        dw_d[c] = DW_LOAD;
                    end
                end
            end
            out_d[c] = (m_d[c] == 10'd0) ? 11'h000 : {s_d[c], m_d[c]};
        end
        settled_d = (st_d[0] == ST_RUN) && (st_d[1] == ST_RUN) &&
                    (out_d[0] == tgt_d[0]) && (out_d[1] == tgt_d[1]);
    end

    // Channel state, targets and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 2; c++) begin
                st_q[c]  <= ST_RUN;
                s_q[c]   <= 1'b0;
                m_q[c]   <= 10'd0;
                dw_q[c]  <= '0;
                tgt_q[c] <= 11'h000;
            end
            lft     <= 11'h000;
            rht     <= 11'h000;
            settled <= 1'b1;
        end else begin
            for (int c = 0; c < 2; c++) begin
                st_q[c]  <= st_d[c];
                s_q[c]   <= s_d[c];
                m_q[c]   <= m_d[c];
                dw_q[c]  <= dw_d[c];
                tgt_q[c] <= tgt_d[c];
            end
            lft     <= out_d[0];
            rht     <= out_d[1];
            settled <= settled_d;
        end
    end

endmodule

// File: doc/motor_ramp_seq.md
# motor_ramp_seq

Command sequencer that sits directly in front of `motor_cntrl` and drives its `lft`/`rht` inputs. It accepts left/right target commands and slews each channel toward its target at a fixed rate. When a channel passes through zero, the block holds it in brake for a dwell period before the channel may move again, so the H-bridges never see an abrupt reversal. The block also provides a synchronous emergency stop and a settled flag for the upstream navigation logic.

## Interface
- `STEP`, 10'd16, magnitude change per ramp tick
- `TICK_DIV`, 1024, clock cycles per ramp tick (≥2)
- `DWELL`, 4096, clock cycles a channel is held at 11'h000 after reaching zero (≥1)

- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `cmd_vld`  in  1  latch `cmd_lft`/`cmd_rht` as new targets this cycle
- `cmd_lft`  in  11  left target: bit10 = reverse, bits 9:0 = magnitude
- `cmd_rht`  in  11  right target, same format
- `estop`  in  1  synchronous emergency stop, level-sensitive
- `lft`  out  11  registered left command to `motor_cntrl`
- `rht`  out  11  registered right command to `motor_cntrl`
- `settled`  out  1  both channels in RUN and outputs equal their targets

## Operation
- **Reset.** Targets = 0, magnitude m = 0, sign s = 0, both channels in RUN, prescaler = 0, `lft` = `rht` = 11'h000, `settled` = 1.
- **Target normalisation.** A target with magnitude 0 is stored as 11'h000; 11'h400 means stop.
- **Target latch.** `cmd_vld` latches both targets on the same edge. Targets may change at any time, including during DWELL.
- **Prescaler.** A free-running counter runs 0..TICK_DIV-1. `tick` is asserted while the count is TICK_DIV-1.
- **Channel output.** Each channel is independent and holds (s, m, state ∈ {RUN, DWELL}, dwell counter). Output is 11'h000 if m = 0, else {s, m}.
- **RUN, on tick, target (S, M):**
  - m = 0 and M ≠ 0: set s ← S and m ← min(STEP, M).
  - m > 0 and S ≠ s: m ← max(m − STEP, 0), saturating.
  - m > 0, S = s, m < M: m ← min(m + STEP, M).
  - m > 0, S = s, m > M: m ← max(m − STEP, M).
  - m = M: hold.
- **Arithmetic width.** Up-step arithmetic is 11-bit internally, so 1023 + STEP cannot wrap.
- **RUN → DWELL.** Any tick that takes m from > 0 to 0 (stop or reversal) moves the channel to DWELL with the counter loaded to DWELL−1.
- **DWELL.** m stays 0 and ticks are ignored. The counter decrements every cycle. When the counter is 0, the next state is RUN.
- **estop.** While high, every cycle: targets ← 0, m ← 0, state ← DWELL, counter ← DWELL−1. estop has priority over `cmd_vld` in the same cycle. Dwell runs out only after estop falls.
- **settled.** Registered; equals (both states RUN) and (lft == target_lft) and (rht == target_rht).

## Timing
- Outputs are registered; all updates take effect on the edge where the tick or control condition is sampled.
- First tick occurs in cycle TICK_DIV−1 after reset release. Steps are spaced exactly TICK_DIV cycles apart.
- Reaching target from 0 takes ceil(M/STEP) ticks.
- A reversal from +m to −M takes:
  - ceil(m/STEP) ticks down, then
  - DWELL cycles at 11'h000, then
  - the first up-step on the next tick.
- estop asserted in cycle n: `lft`/`rht` = 11'h000 from cycle n+1, and `settled` = 0 from cycle n+1.
- `cmd_vld` in cycle n: the target is visible to the tick in cycle n+1 or later. `settled` drops in cycle n+1 if the target differs from the output.
- Reset asserted mid-ramp or mid-dwell: all state returns to reset values immediately, asynchronously.

## Test plan
Bench parameters: STEP=16, TICK_DIV=4, DWELL=8.
1. **Reset values.** Release reset with no commands → `lft` = `rht` = 11'h000 and `settled` = 1, held for 20 cycles.
2. **Forward ramp.** `cmd_lft` = 11'h064 → `lft` steps 0x010, 0x020 … 0x060, 0x064, one step every 4 cycles. `settled` = 1 after the 7th step. `rht` stays 0.
3. **Reversal.** From `lft` = 0x064, command 11'h464 → `lft` steps 0x054 … 0x004, 0x000, then holds 0x000 for 8 cycles, then steps 0x410 … 0x464.
4. **Ramp down to a lower target.** From 0x064, command 11'h028 → `lft` steps 0x054, 0x044, 0x034, 0x028 and holds. No dwell occurs.
5. **estop mid-ramp.** Assert estop for 2 cycles during an up-ramp, with `cmd_vld` asserted in the same cycle → outputs 0x000 from the next cycle and the command is ignored. After estop falls there are 8 dwell cycles, then `settled` = 1 with both outputs 0.
6. **Channel independence.** `cmd_lft` = 11'h030 with `cmd_rht` = 11'h400 → `rht` remains 0x000 and `settled` tracks only the left ramp. Then set `cmd_rht` = 11'h020 → both channels ramp concurrently, with no interaction between them.
